// File: rtl/lsm.sv
// Load-store stage between execute and write-back.
// ALU-only instructions pass straight through with one cycle of latency.
// Memory instructions issue a single-beat pipelined Wishbone access. The
// stage lane-shifts store data and byte selects, and it shifts and extends
// load data.
module lsm (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] result_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        ls_unsigned_load_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,

    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_ACK
    } state_t;

    state_t      state;
    logic        ready_q;

    // Fields of the in-flight memory instruction, captured at accept time
    logic [1:0]  lat_off;
    logic [3:0]  lat_sel;
    logic        lat_unsigned;
    logic        lat_write;
    logic        lat_reg_write;
    logic [4:0]  lat_reg_addr;

    logic [1:0]  in_off;
    logic        in_aligned;
    logic        accept;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;

    assign input_ready_o = ready_q;
    assign accept        = input_valid_i & ready_q;
    assign in_off        = result_i[1:0];

    // Decide whether the incoming access size/offset pair is legal
    always_comb begin
        in_aligned = 1'b0;
        case (ls_sel_i)
            4'b0001: in_aligned = 1'b1;
            4'b0011: in_aligned = ~in_off[0];
            4'b1111: in_aligned = (in_off == 2'b00);
            default: in_aligned = 1'b0;
        endcase
    end

    // Move the addressed lanes of read data down to bit 0, then extend
    always_comb begin
        load_shifted = wb_dat_i >> {lat_off, 3'b000};
        case (lat_sel)
            4'b0001: load_ext = {{24{~lat_unsigned & load_shifted[7]}},  load_shifted[7:0]};
            4'b0011: load_ext = {{16{~lat_unsigned & load_shifted[15]}}, load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // Control FSM. It also drives every registered output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            ready_q        <= 1'b0;
            lat_off        <= '0;
            lat_sel        <= '0;
            lat_unsigned   <= 1'b0;
            lat_write      <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_reg_addr   <= '0;
            wb_adr_o       <= '0;
            wb_dat_o       <= '0;
            wb_we_o        <= 1'b0;
            wb_sel_o       <= '0;
            wb_stb_o       <= 1'b0;
            wb_cyc_o       <= 1'b0;
            output_valid_o <= 1'b0;
            reg_write_o    <= 1'b0;
            reg_addr_o     <= '0;
            reg_data_o     <= '0;
            misaligned_o   <= 1'b0;
        end else begin
            // The completion pulses last one cycle unless a branch below re-asserts them
            output_valid_o <= 1'b0;
            misaligned_o   <= 1'b0;

            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (!ls_enable_i) begin
                            output_valid_o <= 1'b1;
                            reg_write_o    <= reg_write_i;
                            reg_addr_o     <= reg_addr_i;
                            reg_data_o     <= result_i;
                        end else if (!in_aligned) begin
                            // Drop the access. Retire it with no register write.
                            output_valid_o <= 1'b1;
                            misaligned_o   <= 1'b1;
                            reg_write_o    <= 1'b0;
                            reg_addr_o     <= reg_addr_i;
                            reg_data_o     <= '0;
                        end else begin
                            lat_off       <= in_off;
                            lat_sel       <= ls_sel_i;
                            lat_unsigned  <= ls_unsigned_load_i;
                            lat_write     <= ls_write_i;
                            lat_reg_write <= reg_write_i;
                            lat_reg_addr  <= reg_addr_i;
                            wb_adr_o      <= {result_i[31:2], 2'b00};
                            wb_sel_o      <= ls_sel_i << in_off;
                            wb_dat_o      <= ls_write_data_i << {in_off, 3'b000};
                            wb_we_o       <= ls_write_i;
                            wb_stb_o      <= 1'b1;
                            wb_cyc_o      <= 1'b1;
                            ready_q       <= 1'b0;
                            state         <= REQUEST;
                        end
                    end
                end

                REQUEST: begin
                    // Hold the request until the slave takes it. An ack here is ignored.
                    if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        state    <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (wb_ack_i) begin
                        wb_cyc_o       <= 1'b0;
                        wb_we_o        <= 1'b0;
                        wb_sel_o       <= '0;
                        output_valid_o <= 1'b1;
                        reg_addr_o     <= lat_reg_addr;
                        reg_write_o    <= lat_write ? 1'b0 : lat_reg_write;
                        reg_data_o     <= lat_write ? '0 : load_ext;
                        ready_q        <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsm.sv
// Directed testbench for the lsm load-store stage.
module tb_lsm;

    logic        clk_i;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic [31:0] result_i;
    logic        ls_enable_i;
    logic        ls_write_i;
    logic [31:0] ls_write_data_i;
    logic [3:0]  ls_sel_i;
    logic        ls_unsigned_load_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        wb_stall_i;
    logic        output_valid_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o;
    logic        misaligned_o;

    int unsigned n_vec;
    int unsigned n_err;

    lsm dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .input_valid_i      (input_valid_i),
        .input_ready_o      (input_ready_o),
        .result_i           (result_i),
        .ls_enable_i        (ls_enable_i),
        .ls_write_i         (ls_write_i),
        .ls_write_data_i    (ls_write_data_i),
        .ls_sel_i           (ls_sel_i),
        .ls_unsigned_load_i (ls_unsigned_load_i),
        .reg_write_i        (reg_write_i),
        .reg_addr_i         (reg_addr_i),
        .wb_adr_o           (wb_adr_o),
        .wb_dat_o           (wb_dat_o),
        .wb_dat_i           (wb_dat_i),
        .wb_we_o            (wb_we_o),
        .wb_sel_o           (wb_sel_o),
        .wb_stb_o           (wb_stb_o),
        .wb_cyc_o           (wb_cyc_o),
        .wb_ack_i           (wb_ack_i),
        .wb_stall_i         (wb_stall_i),
        .output_valid_o     (output_valid_o),
        .reg_write_o        (reg_write_o),
        .reg_addr_o         (reg_addr_o),
        .reg_data_o         (reg_data_o),
        .misaligned_o       (misaligned_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one instruction for exactly one accepting edge
    task automatic issue(input logic [31:0] res, input logic ls, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] sel,
                         input logic uns, input logic rw, input logic [4:0] rd);
        result_i           = res;
        ls_enable_i        = ls;
        ls_write_i         = wr;
        ls_write_data_i    = wdata;
        ls_sel_i           = sel;
        ls_unsigned_load_i = uns;
        reg_write_i        = rw;
        reg_addr_i         = rd;
        input_valid_i      = 1'b1;
        step();
        input_valid_i      = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_i = 1'b0;
        input_valid_i = 1'b0;
        result_i = '0;
        ls_enable_i = 1'b0;
        ls_write_i = 1'b0;
        ls_write_data_i = '0;
        ls_sel_i = '0;
        ls_unsigned_load_i = 1'b0;
        reg_write_i = 1'b0;
        reg_addr_i = '0;
        wb_dat_i = '0;
        wb_ack_i = 1'b0;
        wb_stall_i = 1'b0;

        // Reset state
        #1;
        chk("rst_ready", 32'(input_ready_o), 32'd0);
        chk("rst_cyc",   32'(wb_cyc_o), 32'd0);
        chk("rst_ovalid", 32'(output_valid_o), 32'd0);
        chk("rst_data",  reg_data_o, 32'd0);
        step();
        step();
        rst_i = 1'b1;
        step();
        chk("ready_after_rst", 32'(input_ready_o), 32'd1);

        // ALU passthrough, three instructions back to back
        issue(32'h1234_5678, 1'b0, 1'b0, 32'd0, 4'b0000, 1'b0, 1'b1, 5'd5);
        chk("alu0_valid", 32'(output_valid_o), 32'd1);
        chk("alu0_data",  reg_data_o, 32'h1234_5678);
        chk("alu0_addr",  32'(reg_addr_o), 32'd5);
        chk("alu0_we",    32'(reg_write_o), 32'd1);
        chk("alu0_ready", 32'(input_ready_o), 32'd1);
        issue(32'h1111_1111, 1'b0, 1'b0, 32'd0, 4'b0000, 1'b0, 1'b1, 5'd6);
        chk("alu1_valid", 32'(output_valid_o), 32'd1);
        chk("alu1_data",  reg_data_o, 32'h1111_1111);
        issue(32'h2222_2222, 1'b0, 1'b0, 32'd0, 4'b0000, 1'b0, 1'b0, 5'd7);
        chk("alu2_valid", 32'(output_valid_o), 32'd1);
        chk("alu2_data",  reg_data_o, 32'h2222_2222);
        chk("alu2_we",    32'(reg_write_o), 32'd0);
        step();
        chk("alu_idle_valid", 32'(output_valid_o), 32'd0);

        // Signed byte load at 0x1003; ack two cycles after the strobe is taken
        issue(32'h0000_1003, 1'b1, 1'b0, 32'd0, 4'b0001, 1'b0, 1'b1, 5'd9);
        chk("lb_cyc",   32'(wb_cyc_o), 32'd1);
        chk("lb_stb",   32'(wb_stb_o), 32'd1);
        chk("lb_adr",   wb_adr_o, 32'h0000_1000);
        chk("lb_sel",   32'(wb_sel_o), 32'h8);
        chk("lb_we",    32'(wb_we_o), 32'd0);
        chk("lb_ready", 32'(input_ready_o), 32'd0);
        step();
        chk("lb_stb_drop", 32'(wb_stb_o), 32'd0);
        chk("lb_cyc_hold", 32'(wb_cyc_o), 32'd1);
        step();
        chk("lb_wait_valid", 32'(output_valid_o), 32'd0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h80AA_BBCC;
        step();
        wb_ack_i = 1'b0;
        chk("lb_valid", 32'(output_valid_o), 32'd1);
        chk("lb_data",  reg_data_o, 32'hFFFF_FF80);
        chk("lb_addr",  32'(reg_addr_o), 32'd9);
        chk("lb_rwe",   32'(reg_write_o), 32'd1);
        chk("lb_cyc_end", 32'(wb_cyc_o), 32'd0);
        chk("lb_ready_end", 32'(input_ready_o), 32'd1);
        step();
        chk("lb_valid_pulse", 32'(output_valid_o), 32'd0);

        // Unsigned half load at 0x2002
        issue(32'h0000_2002, 1'b1, 1'b0, 32'd0, 4'b0011, 1'b1, 1'b1, 5'd10);
        chk("lhu_adr", wb_adr_o, 32'h0000_2000);
        chk("lhu_sel", 32'(wb_sel_o), 32'hC);
        step();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h9ABC_0000;
        step();
        wb_ack_i = 1'b0;
        chk("lhu_valid", 32'(output_valid_o), 32'd1);
        chk("lhu_data",  reg_data_o, 32'h0000_9ABC);

        // Byte store at 0x3001 held by stall for three cycles, with a stray ack
        wb_stall_i = 1'b1;
        issue(32'h0000_3001, 1'b1, 1'b1, 32'h0000_00EF, 4'b0001, 1'b0, 1'b1, 5'd11);
        chk("sb_sel", 32'(wb_sel_o), 32'h2);
        chk("sb_dat", wb_dat_o, 32'h0000_EF00);
        chk("sb_we",  32'(wb_we_o), 32'd1);
        chk("sb_adr", wb_adr_o, 32'h0000_3000);
        wb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            wb_ack_i = 1'b0;
            chk("sb_stall_stb",   32'(wb_stb_o), 32'd1);
            chk("sb_stall_dat",   wb_dat_o, 32'h0000_EF00);
            chk("sb_stall_ready", 32'(input_ready_o), 32'd0);
            chk("sb_stall_valid", 32'(output_valid_o), 32'd0);
        end
        wb_stall_i = 1'b0;
        step();
        chk("sb_stb_drop", 32'(wb_stb_o), 32'd0);
        chk("sb_wait_ready", 32'(input_ready_o), 32'd0);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        chk("sb_valid", 32'(output_valid_o), 32'd1);
        chk("sb_rwe",   32'(reg_write_o), 32'd0);
        chk("sb_data",  reg_data_o, 32'd0);
        chk("sb_ready", 32'(input_ready_o), 32'd1);

        // Misaligned word, misaligned half, and an illegal select value
        issue(32'h0000_4002, 1'b1, 1'b0, 32'd0, 4'b1111, 1'b0, 1'b1, 5'd12);
        chk("mw_cyc",   32'(wb_cyc_o), 32'd0);
        chk("mw_mis",   32'(misaligned_o), 32'd1);
        chk("mw_valid", 32'(output_valid_o), 32'd1);
        chk("mw_rwe",   32'(reg_write_o), 32'd0);
        chk("mw_ready", 32'(input_ready_o), 32'd1);
        issue(32'h0000_4001, 1'b1, 1'b0, 32'd0, 4'b0011, 1'b0, 1'b1, 5'd13);
        chk("mh_mis", 32'(misaligned_o), 32'd1);
        chk("mh_cyc", 32'(wb_cyc_o), 32'd0);
        issue(32'h0000_4000, 1'b1, 1'b0, 32'd0, 4'b0101, 1'b0, 1'b1, 5'd14);
        chk("msel_mis", 32'(misaligned_o), 32'd1);
        step();
        chk("mis_pulse", 32'(misaligned_o), 32'd0);
        chk("mis_valid_pulse", 32'(output_valid_o), 32'd0);

        // Reset asserted during WAIT_ACK, then a late ack
        issue(32'h0000_5000, 1'b1, 1'b0, 32'd0, 4'b1111, 1'b0, 1'b1, 5'd15);
        step();
        chk("rw_cyc_wait", 32'(wb_cyc_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("rw_cyc",   32'(wb_cyc_o), 32'd0);
        chk("rw_adr",   wb_adr_o, 32'd0);
        chk("rw_ready", 32'(input_ready_o), 32'd0);
        chk("rw_addr",  32'(reg_addr_o), 32'd0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        step();
        rst_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        chk("late_ack_valid", 32'(output_valid_o), 32'd0);
        chk("late_ack_cyc",   32'(wb_cyc_o), 32'd0);
        chk("late_ack_ready", 32'(input_ready_o), 32'd1);

        // Normal word and signed half loads after the reset
        issue(32'h0000_6000, 1'b1, 1'b0, 32'd0, 4'b1111, 1'b0, 1'b1, 5'd16);
        chk("lw_sel", 32'(wb_sel_o), 32'hF);
        step();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1357_2468;
        step();
        wb_ack_i = 1'b0;
        chk("lw_data", reg_data_o, 32'h1357_2468);
        chk("lw_addr", 32'(reg_addr_o), 32'd16);
        issue(32'h0000_6002, 1'b1, 1'b0, 32'd0, 4'b0011, 1'b0, 1'b1, 5'd17);
        step();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h8001_0000;
        step();
        wb_ack_i = 1'b0;
        chk("lh_data", reg_data_o, 32'hFFFF_8001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
